// File: rtl/reg_file_serial_loader_pkg.sv
// Shared definitions for the register-file serial loader.
//   - Default register-file geometry (ADDR_W_DEF / DATA_W_DEF).
//   - FSM state encoding, op-bit encoding and frame-length helpers.
package reg_file_serial_loader_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam logic OP_WRITE = 1'b1;

  // start + op + addr + data + stop
  function automatic int frame_len(input int addr_w, input int data_w);
    return 2 + addr_w + data_w + 1;
  endfunction

  localparam int FRAME_LEN = frame_len(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/serial_shift_counter.sv
// Shift register plus bit counter for the serial loader payload.
//   clk, rst_n : clock, asynchronous active-low reset
//   shift      : shift din into the LSB and advance the counter
//   clear      : zero both the shift register and the counter
//   din        : serial input bit
//   data       : shift-register contents, first received bit in the MSB
//   last_bit   : the next shift completes the payload
module serial_shift_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] data,
  output logic             last_bit
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] count;

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, exactly like flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift) begin
      data  <= {data[WIDTH-2:0], din};
      // Wrap on the final bit so the counter is ready for the next frame.
      count <= last_bit ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_serial_loader.sv
// Serial command front-end for a small register file.
// Deserialises start/op/addr/data/stop frames from sdi (sampled on bit_en)
// into register-file writes or registered reads.
//   clk, rst_n : clock, asynchronous active-low reset
//   bit_en     : bit-sample strobe
//   sdi        : serial data in, idles high
//   rf_we      : file write enable (one-cycle pulse)
//   rf_addr    : file address (holds until the next accepted frame)
//   rf_wdata   : file write data (holds until the next accepted frame)
//   rf_rdata   : file combinational read data
//   rd_data    : captured read result
//   rd_valid   : one-cycle pulse, rd_data is new
//   frame_err  : one-cycle pulse, bad stop bit
//   busy       : FSM is not idle
module reg_file_serial_loader
  import reg_file_serial_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              sdi,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_err,
  output logic              busy
);

  // Payload is everything between start and stop: op, addr, data.
  localparam int PAYLOAD_W = frame_len(ADDR_W, DATA_W) - 2;

  state_t                 state;
  logic [PAYLOAD_W-1:0]   payload;
  logic                   last_bit;
  logic                   shift;
  logic                   clear;

  assign shift = bit_en && (state == ST_SHIFT);
  // Clearing on the start bit gives each frame a fresh counter and payload.
  assign clear = bit_en && (state == ST_IDLE) && !sdi;

  serial_shift_counter #(
    .WIDTH(PAYLOAD_W)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift   (shift),
    .clear   (clear),
    .din     (sdi),
    .data    (payload),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rf_we     <= 1'b0;
      rf_addr   <= '0;
      rf_wdata  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      rf_we     <= 1'b0;
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bit_en && !sdi) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bit_en && last_bit) begin
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (bit_en) begin
            if (sdi) begin
              rf_addr  <= payload[DATA_W +: ADDR_W];
              rf_wdata <= payload[DATA_W-1:0];
              if (payload[PAYLOAD_W-1] == OP_WRITE) begin
                state <= ST_WRITE;
                rf_we <= 1'b1;
              end else begin
                state <= ST_READ;
              end
            end else begin
              // Bad stop bit: drop the frame, touch nothing but frame_err.
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        ST_READ: begin
          // rf_addr has been stable for this whole cycle, so rf_rdata is valid.
          rd_data  <= rf_rdata;
          rd_valid <= 1'b1;
          state    <= ST_IDLE;
          busy     <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_serial_loader.sv
// Self-checking bench for reg_file_serial_loader: directed frames from the
// test plan followed by random frames, checked against a simple memory model.
module tb_reg_file_serial_loader;
  import reg_file_serial_loader_pkg::*;

  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_en;
  logic          sdi;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  reg_file_serial_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_en   (bit_en),
    .sdi      (sdi),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // The 4x4 register file the loader drives.
  logic [DW-1:0] rf_mem [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
  assign rf_rdata = rf_mem[rf_addr];

  // Cycle stamps: a sample taken at posedge k is stamped k; outputs updated
  // by that edge are seen at the following negedge with cyc == k+1.
  int cyc = 0;
  int stop_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bit_en) stop_cyc <= cyc;
  end

  int            we_cnt = 0, rv_cnt = 0, fe_cnt = 0, busy_cnt = 0;
  int            we_cyc = 0, rv_cyc = 0;
  logic [AW-1:0] we_addr = '0;
  logic [DW-1:0] we_data = '0;
  logic [DW-1:0] rv_data = '0;
  always @(negedge clk) begin
    if (rf_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= rf_addr;
      we_data <= rf_wdata;
      we_cyc  <= cyc;
    end
    if (rd_valid) begin
      rv_cnt  <= rv_cnt + 1;
      rv_data <= rd_data;
      rv_cyc  <= cyc;
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Reference model: expected file contents and last accepted addr/data.
  logic [DW-1:0] exp_mem [4];
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sample followed by the minimum two-clock bit_en gap.
  // Called and returns on a falling edge.
  task automatic sample(input logic b);
    bit_en = 1'b1;
    sdi    = b;
    @(negedge clk);
    bit_en = 1'b0;
    sdi    = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic op, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic stop);
    logic [FRAME_LEN-1:0] bits;
    bits = {1'b0, op, a, d, stop};
    for (int i = FRAME_LEN - 1; i >= 0; i--) sample(bits[i]);
  endtask

  task automatic do_frame(input string tag, input logic op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic stop);
    int we0, rv0, fe0;
    we0 = we_cnt;
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    send_frame(op, a, d, stop);
    if (!stop) begin
      check({tag, "/fe_pulses"}, fe_cnt - fe0, 1);
      check({tag, "/we_pulses"}, we_cnt - we0, 0);
      check({tag, "/rv_pulses"}, rv_cnt - rv0, 0);
      check({tag, "/addr_held"}, rf_addr, acc_addr);
      check({tag, "/wdata_held"}, rf_wdata, acc_data);
    end else if (op) begin
      exp_mem[a] = d;
      acc_addr   = a;
      acc_data   = d;
      check({tag, "/we_pulses"}, we_cnt - we0, 1);
      check({tag, "/we_addr"}, we_addr, a);
      check({tag, "/we_data"}, we_data, d);
      check({tag, "/we_latency"}, we_cyc - stop_cyc, 1);
      check({tag, "/rv_pulses"}, rv_cnt - rv0, 0);
      check({tag, "/fe_pulses"}, fe_cnt - fe0, 0);
      check({tag, "/file"}, rf_mem[a], d);
    end else begin
      acc_addr = a;
      acc_data = d;
      check({tag, "/rv_pulses"}, rv_cnt - rv0, 1);
      check({tag, "/rd_data"}, rv_data, exp_mem[a]);
      check({tag, "/rv_latency"}, rv_cyc - stop_cyc, 2);
      check({tag, "/we_pulses"}, we_cnt - we0, 0);
      check({tag, "/fe_pulses"}, fe_cnt - fe0, 0);
      check({tag, "/rf_addr"}, rf_addr, a);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rf_we"}, rf_we, 0);
    check({tag, "/rf_addr"}, rf_addr, 0);
    check({tag, "/rf_wdata"}, rf_wdata, 0);
    check({tag, "/rd_data"}, rd_data, 0);
    check({tag, "/rd_valid"}, rd_valid, 0);
    check({tag, "/frame_err"}, frame_err, 0);
    check({tag, "/busy"}, busy, 0);
  endtask

  initial begin
    int we0, rv0, fe0, b0;
    logic [8:0] wbits;

    rst_n  = 1'b0;
    bit_en = 1'b0;
    sdi    = 1'b1;
    for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    acc_addr = '0;
    acc_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames from the test plan.
    do_frame("wr_a2", 1'b1, 2'd2, 4'hA, 1'b1);
    do_frame("rd_a2", 1'b0, 2'd2, 4'h0, 1'b1);
    do_frame("bad_stop", 1'b1, 2'd1, 4'h5, 1'b0);

    // Back-to-back writes then read-back, no idle samples between frames.
    for (int i = 0; i < 4; i++) do_frame("b2b_wr", 1'b1, 2'(i), 4'(1 << i), 1'b1);
    for (int i = 0; i < 4; i++) do_frame("b2b_rd", 1'b0, 2'(i), 4'h0, 1'b1);

    // Reset after the 5th sample of a write frame to addr 2.
    we0 = we_cnt;
    sample(1'b0); sample(1'b1); sample(1'b1); sample(1'b0); sample(1'b1);
    check("midreset/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    acc_addr = '0;
    acc_data = '0;
    @(negedge clk);
    check("midreset/no_write", we_cnt - we0, 0);
    check("midreset/file_a2", rf_mem[2], exp_mem[2]);
    do_frame("after_reset", 1'b1, 2'd3, 4'h6, 1'b1);

    // Reset during the WRITE cycle: rf_we must drop before the commit edge.
    wbits = {1'b0, 1'b1, 2'd1, 4'hF, 1'b1};
    for (int i = 8; i >= 1; i--) sample(wbits[i]);
    bit_en = 1'b1;
    sdi    = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    check("wrreset/we_before", rf_we, 1);
    rst_n = 1'b0;
    #1;
    check("wrreset/we_dropped", rf_we, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    acc_addr = '0;
    acc_data = '0;
    @(negedge clk);
    check("wrreset/file_a1", rf_mem[1], exp_mem[1]);
    do_frame("after_wrreset", 1'b0, 2'd1, 4'h0, 1'b1);

    // Idle line.
    we0 = we_cnt; rv0 = rv_cnt; fe0 = fe_cnt; b0 = busy_cnt;
    repeat (20) sample(1'b1);
    check("idle/busy_cycles", busy_cnt - b0, 0);
    check("idle/we_pulses", we_cnt - we0, 0);
    check("idle/rv_pulses", rv_cnt - rv0, 0);
    check("idle/fe_pulses", fe_cnt - fe0, 0);

    // Random frames with occasional bad stop bits and idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic          r_op, r_stop;
      logic [AW-1:0] r_a;
      logic [DW-1:0] r_d;
      r_op   = 1'($urandom_range(0, 1));
      r_a    = AW'($urandom_range(0, 3));
      r_d    = DW'($urandom_range(0, 15));
      r_stop = ($urandom_range(0, 5) != 0);
      do_frame("rand", r_op, r_a, r_d, r_stop);
      repeat ($urandom_range(0, 2)) sample(1'b1);
    end

    for (int i = 0; i < 4; i++) check("final/file", rf_mem[i], exp_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_serial_loader.md
# reg_file_serial_loader

Serial command front-end placed directly upstream of the 4x4 register file. It deserialises a one-wire bit stream into write and read commands. Write commands drive the file's write port (`we`, `addr`, `data_in`). Read commands steer its combinational read port and capture `data_out` into a registered result with a valid strobe. A small FSM, a bit counter and a shift register do the work; malformed frames are rejected and never reach the file.

## Interface
- `ADDR_W`, default 2: register-file address width; must match the file.
- `DATA_W`, default 4: register-file data width; must match the file.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_en`  in  1  bit-sample strobe; `sdi` is sampled only on `clk` edges where `bit_en`=1.
- `sdi`  in  1  serial data in; idles high.
- `rf_we`  out  1  to file `we`.
- `rf_addr`  out  ADDR_W  to file `addr`.
- `rf_wdata`  out  DATA_W  to file `data_in`.
- `rf_rdata`  in  DATA_W  from file `data_out`.
- `rd_data`  out  DATA_W  captured read result.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is new.
- `frame_err`  out  1  one-cycle pulse; bad stop bit.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Frame format, in sample order: start(0), op (1=write, 0=read), addr MSB-first (ADDR_W bits), data MSB-first (DATA_W bits), stop(1). Total 2+ADDR_W+DATA_W+1 = 9 samples at defaults.
- Read frames still carry data bits; they are shifted in and discarded.
- FSM states:
  - IDLE -> SHIFT on a sample with `sdi`=0. A sample with `sdi`=1 stays in IDLE.
  - SHIFT: shifts 1+ADDR_W+DATA_W samples into the shift register, counted by the bit counter, then -> STOP.
  - STOP: on the next sample, stop=1 and op=1 -> WRITE; stop=1 and op=0 -> READ; stop=0 -> IDLE and pulse `frame_err` for one cycle.
  - WRITE: `rf_we`=1 for exactly one cycle, then -> IDLE.
  - READ: one cycle, then -> IDLE. `rd_data` <= `rf_rdata` at the end of this cycle; `rd_valid`=1 in the following cycle.
- `rf_addr` and `rf_wdata` are loaded from the shift register on the STOP->WRITE and STOP->READ transitions. Both hold their value until the next accepted frame.
- A frame with a bad stop bit changes no output except `frame_err`.
- All outputs are registered.
- Reset values:
  - state IDLE, bit counter 0, shift register 0.
  - `rf_we`=0, `rf_addr`=0, `rf_wdata`=0, `rd_data`=0, `rd_valid`=0, `frame_err`=0, `busy`=0.

## Timing
- Write latency: `rf_we` is high in the clock cycle right after the stop-bit sample edge. The file commits the write on the following edge.
- Read latency: `rf_addr` is valid in the cycle after the stop sample. `rd_data`/`rd_valid` update one cycle later, i.e. 2 clocks after the stop sample.
- `bit_en` pulses must be separated by at least 2 clocks with `bit_en` low. Samples are not taken in WRITE or READ.
- The start bit of the next frame may arrive on the first legal `bit_en` after the stop bit; back-to-back frames must not be lost.
- `sdi` is assumed synchronous to `clk`. No synchroniser is placed inside this block.
- Reset asserted mid-frame:
  - `rf_we` drops immediately and the partial frame is discarded.
  - No write reaches the file.
  - After release, the FSM waits in IDLE for a fresh start bit.
- `bit_en`=0 for any duration freezes the FSM and counter. No timeout is applied.

## Structure
- Shared package/header holds: `ADDR_W`/`DATA_W` defaults, the state encodings (IDLE, SHIFT, STOP, WRITE, READ), `OP_WRITE`=1, and the frame-length constant.
- One natural sub-module: `serial_shift_counter`. It combines the shift register with the bit counter and has shift/clear inputs and a `last_bit` output.
- The FSM and output registers stay in the top module.

## Test plan
- Write 0xA to addr 2, frame 0,1,1,0,1,0,1,0,1 -> exactly one `rf_we` pulse with `rf_addr`=2 and `rf_wdata`=0xA; file reg2=0xA.
- Read addr 2 after that write, frame 0,0,1,0,0,0,0,0,1 -> `rd_valid` pulse with `rd_data`=0xA, 2 clocks after the stop sample; `rf_we` never high.
- Bad stop: write frame for addr 1, data 0x5 with stop=0 -> one `frame_err` pulse, no `rf_we`, `rf_addr`/`rf_wdata` unchanged.
- Back-to-back writes to addrs 0..3 with data 0x1, 0x2, 0x4, 0x8 and no idle gap between frames -> four `rf_we` pulses in order; read-back of all four returns those values.
- Reset asserted after the 5th sample of a write frame -> all outputs return to reset values at once; no write; a following full frame is accepted normally.
- Idle line (`sdi`=1) for 20 `bit_en` pulses -> `busy`=0 throughout, no pulses on any strobe output.
